// File: rtl/echo_ctrl_pkg.sv
// rtl/echo_ctrl_pkg.sv - shared widths, defaults and FSM state type for the sample sequencer
package echo_ctrl_pkg;

  localparam int SAMPLE_W               = 16;
  localparam int CNT_W                  = 13;
  localparam int DEFAULT_SAMPLING_CYCLE = 40;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_CONVERT    = 2'd1,
    ST_WAIT_READY = 2'd2,
    ST_PROCESS    = 2'd3
  } seq_state_t;

endpackage

// File: rtl/sampling_tick_gen.sv
// rtl/sampling_tick_gen.sv - sample-period counter and sample tick
module sampling_tick_gen
  import echo_ctrl_pkg::*;
#(
  parameter int SAMPLING_CYCLE = DEFAULT_SAMPLING_CYCLE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  output logic [CNT_W-1:0] counter,
  output logic             tick
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next position: parked at zero while stopped so the first tick lands on the first run cycle
  always_comb begin
    cnt_d = '0;
    if (run) begin
      if (cnt_q == CNT_W'(SAMPLING_CYCLE - 1)) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Period counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign counter = cnt_q;
  assign tick    = run && (cnt_q == '0);

endmodule

// File: rtl/sample_conversion_sequencer.sv
// rtl/sample_conversion_sequencer.sv - per-sample convert/process/output scheduler with sticky error flags
module sample_conversion_sequencer
  import echo_ctrl_pkg::*;
#(
  parameter int SAMPLING_CYCLE = DEFAULT_SAMPLING_CYCLE,
  parameter int ENABLE_CYCLES  = 2,
  parameter int READY_TIMEOUT  = 16
) (
  input  logic                clk_operation,
  input  logic                rst,
  input  logic                run,
  input  logic                clr_err,
  input  logic [SAMPLE_W-1:0] sig16b_in,
  input  logic                cnv_ready,
  input  logic                proc_done,
  output logic [CNT_W-1:0]    sampling_cycle_counter,
  output logic                sampling_light,
  output logic [SAMPLE_W-1:0] sample_latched,
  output logic                cnv_enable,
  output logic                proc_start,
  output logic                out_enable,
  output logic                busy,
  output logic                overrun,
  output logic                timeout_err,
  output logic [15:0]         sample_count
);

  localparam int EN_W = $clog2(ENABLE_CYCLES + 1);
  localparam int TO_W = $clog2(READY_TIMEOUT + 1);

  seq_state_t          state_q, state_d;
  logic [EN_W-1:0]     en_cnt_q, en_cnt_d;
  logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
  logic [SAMPLE_W-1:0] sample_q, sample_d;
  logic                cnv_enable_q, cnv_enable_d;
  logic                proc_start_q, proc_start_d;
  logic                out_enable_q, out_enable_d;
  logic                busy_q, busy_d;
  logic                overrun_q, overrun_d;
  logic                timeout_q, timeout_d;
  logic [15:0]         count_q, count_d;
  logic                tick;

  sampling_tick_gen #(
    .SAMPLING_CYCLE(SAMPLING_CYCLE)
  ) u_tick_gen (
    .clk     (clk_operation),
    .rst     (rst),
    .run     (run),
    .counter (sampling_cycle_counter),
    .tick    (tick)
  );

  // Sequencer next state and registered outputs; cnv_ready is not looked at until CONVERT ends
  always_comb begin
    state_d      = state_q;
    en_cnt_d     = en_cnt_q;
    to_cnt_d     = to_cnt_q;
    sample_d     = sample_q;
    cnv_enable_d = 1'b0;
    proc_start_d = 1'b0;
    out_enable_d = 1'b0;
    count_d      = count_q;
    overrun_d    = overrun_q & ~clr_err;
    timeout_d    = timeout_q & ~clr_err;

    // A tick landing on any non-idle edge, including the one leaving for IDLE, is lost
    if (tick && (state_q != ST_IDLE)) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (tick) begin
          sample_d     = sig16b_in;
          cnv_enable_d = 1'b1;
          en_cnt_d     = EN_W'(1);
          state_d      = ST_CONVERT;
        end
      end
      ST_CONVERT: begin
        if (en_cnt_q == EN_W'(ENABLE_CYCLES)) begin
          to_cnt_d = '0;
          state_d  = ST_WAIT_READY;
        end else begin
          cnv_enable_d = 1'b1;
          en_cnt_d     = en_cnt_q + EN_W'(1);
        end
      end
      ST_WAIT_READY: begin
        if (cnv_ready) begin
          proc_start_d = 1'b1;
          state_d      = ST_PROCESS;
        end else if (to_cnt_q == TO_W'(READY_TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      ST_PROCESS: begin
        if (proc_done) begin
          out_enable_d = 1'b1;
          count_d      = count_q + 16'd1;
          state_d      = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State, counters, outputs and sticky flags; reset abandons any in-flight sample
  always_ff @(posedge clk_operation) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      en_cnt_q     <= '0;
      to_cnt_q     <= '0;
      sample_q     <= '0;
      cnv_enable_q <= 1'b0;
      proc_start_q <= 1'b0;
      out_enable_q <= 1'b0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
      timeout_q    <= 1'b0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      en_cnt_q     <= en_cnt_d;
      to_cnt_q     <= to_cnt_d;
      sample_q     <= sample_d;
      cnv_enable_q <= cnv_enable_d;
      proc_start_q <= proc_start_d;
      out_enable_q <= out_enable_d;
      busy_q       <= busy_d;
      overrun_q    <= overrun_d;
      timeout_q    <= timeout_d;
      count_q      <= count_d;
    end
  end

  assign sampling_light = tick;
  assign sample_latched = sample_q;
  assign cnv_enable     = cnv_enable_q;
  assign proc_start     = proc_start_q;
  assign out_enable     = out_enable_q;
  assign busy           = busy_q;
  assign overrun        = overrun_q;
  assign timeout_err    = timeout_q;
  assign sample_count   = count_q;

endmodule

// File: tb/tb_sample_conversion_sequencer.sv
// tb/tb_sample_conversion_sequencer.sv - self-checking bench for sample_conversion_sequencer
module tb_sample_conversion_sequencer;

  logic        clk_operation = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic        clr_err = 1'b0;
  logic [15:0] sig16b_in = 16'h0000;
  logic        cnv_ready = 1'b0;
  logic        proc_done = 1'b0;
  logic [12:0] sampling_cycle_counter;
  logic        sampling_light;
  logic [15:0] sample_latched;
  logic        cnv_enable;
  logic        proc_start;
  logic        out_enable;
  logic        busy;
  logic        overrun;
  logic        timeout_err;
  logic [15:0] sample_count;

  int checks = 0;
  int errors = 0;
  int n_start = 0;
  int n_out = 0;

  typedef struct packed {
    logic [15:0] latched;
    logic [15:0] count;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] exp_count = 16'd0;

  sample_conversion_sequencer #(
    .SAMPLING_CYCLE(40),
    .ENABLE_CYCLES (2),
    .READY_TIMEOUT (16)
  ) dut (
    .clk_operation          (clk_operation),
    .rst                    (rst),
    .run                    (run),
    .clr_err                (clr_err),
    .sig16b_in              (sig16b_in),
    .cnv_ready              (cnv_ready),
    .proc_done              (proc_done),
    .sampling_cycle_counter (sampling_cycle_counter),
    .sampling_light         (sampling_light),
    .sample_latched         (sample_latched),
    .cnv_enable             (cnv_enable),
    .proc_start             (proc_start),
    .out_enable             (out_enable),
    .busy                   (busy),
    .overrun                (overrun),
    .timeout_err            (timeout_err),
    .sample_count           (sample_count)
  );

  always #5 clk_operation = ~clk_operation;

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard: every out_enable must match the oldest accepted sample
  always @(negedge clk_operation) begin
    exp_t e;
    if (proc_start) n_start++;
    if (out_enable) begin
      n_out++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_out got out_enable=1 want no pending sample");
      end else begin
        e = exp_q.pop_front();
        if (sample_latched !== e.latched) begin
          errors++;
          $display("FAIL sb_latched got %h want %h", sample_latched, e.latched);
        end
        checks++;
        if (sample_count !== e.count) begin
          errors++;
          $display("FAIL sb_count got %0d want %0d", sample_count, e.count);
        end
      end
    end
  end

  task automatic step();
    @(negedge clk_operation);
  endtask

  task automatic wait_tick(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      #1;
      if (sampling_light) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic wait_enable_low(output int width, output bit ok);
    width = 0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (!cnv_enable) begin
        ok = 1'b1;
        break;
      end
      width++;
      step();
    end
  endtask

  task automatic wait_start(output int n, output bit ok);
    n = 0;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      n++;
      if (proc_start) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic accept(input logic [15:0] value);
    sig16b_in = value;
    exp_count = exp_count + 16'd1;
    exp_q.push_back({value, exp_count});
    step();
  endtask

  task automatic finish_process();
    proc_done = 1'b1;
    step();
    proc_done = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    run = 1'b0;
    repeat (3) step();
    checks++;
    if ({sampling_cycle_counter, sampling_light, sample_latched, cnv_enable, proc_start,
         out_enable, busy, overrun, timeout_err, sample_count} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got cnt=%0d lat=%h en=%b st=%b oe=%b busy=%b ovr=%b to=%b sc=%0d want all 0",
               sampling_cycle_counter, sample_latched, cnv_enable, proc_start, out_enable,
               busy, overrun, timeout_err, sample_count);
    end
    rst = 1'b0;
    repeat (2) step();
    checks++;
    if (sampling_cycle_counter !== 13'd0 || sampling_light !== 1'b0) begin
      errors++;
      $display("FAIL idle_counter got cnt=%0d light=%b want 0 0", sampling_cycle_counter, sampling_light);
    end
  endtask

  task automatic test_nominal();
    int w, n, s0;
    bit ok;
    s0 = n_start;
    run = 1'b1;
    #1;
    checks++;
    if (sampling_light !== 1'b1) begin
      errors++;
      $display("FAIL first_tick got light=%b want 1", sampling_light);
    end
    accept(16'h1234);
    sig16b_in = 16'hBEEF;
    checks++;
    if (sample_latched !== 16'h1234 || busy !== 1'b1) begin
      errors++;
      $display("FAIL nominal_latch got lat=%h busy=%b want 1234 1", sample_latched, busy);
    end
    wait_enable_low(w, ok);
    checks++;
    if (!ok || w != 2) begin
      errors++;
      $display("FAIL nominal_enable_width got %0d ok=%b want 2", w, ok);
    end
    repeat (3) step();
    cnv_ready = 1'b1;
    wait_start(n, ok);
    cnv_ready = 1'b0;
    checks++;
    if (!ok || n != 1) begin
      errors++;
      $display("FAIL nominal_start_latency got %0d ok=%b want 1", n, ok);
    end
    repeat (4) step();
    finish_process();
    checks++;
    if (out_enable !== 1'b1 || sample_count !== 16'd1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL nominal_done got oe=%b sc=%0d busy=%b want 1 1 0", out_enable, sample_count, busy);
    end
    step();
    #1;
    checks++;
    if (out_enable !== 1'b0 || n_start - s0 != 1) begin
      errors++;
      $display("FAIL nominal_single_pulse got oe=%b starts=%0d want 0 1", out_enable, n_start - s0);
    end
    wait_tick(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL nominal_second_tick got none want tick within 60 cycles");
    end
    accept(16'h5678);
    wait_enable_low(w, ok);
    cnv_ready = 1'b1;
    wait_start(n, ok);
    cnv_ready = 1'b0;
    finish_process();
    checks++;
    if (sample_count !== 16'd2 || sample_latched !== 16'h5678) begin
      errors++;
      $display("FAIL nominal_second got sc=%0d lat=%h want 2 5678", sample_count, sample_latched);
    end
  endtask

  task automatic test_timeout();
    int w, k, s0, n;
    bit ok;
    wait_tick(ok);
    sig16b_in = 16'h0F0F;
    step();
    s0 = n_start;
    wait_enable_low(w, ok);
    k = 0;
    for (int i = 0; i < 40; i++) begin
      if (timeout_err) break;
      step();
      k++;
    end
    checks++;
    if (k != 16) begin
      errors++;
      $display("FAIL timeout_latency got %0d want 16", k);
    end
    checks++;
    if (busy !== 1'b0 || sample_count !== exp_count || n_start != s0) begin
      errors++;
      $display("FAIL timeout_drop got busy=%b sc=%0d starts=%0d want 0 %0d 0",
               busy, sample_count, n_start - s0, exp_count);
    end
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    #1;
    checks++;
    if (timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL timeout_clear got %b want 0", timeout_err);
    end
    wait_tick(ok);
    accept(16'h2468);
    checks++;
    if (cnv_enable !== 1'b1) begin
      errors++;
      $display("FAIL timeout_next_accept got en=%b want 1", cnv_enable);
    end
    wait_enable_low(w, ok);
    cnv_ready = 1'b1;
    wait_start(n, ok);
    cnv_ready = 1'b0;
    finish_process();
    checks++;
    if (sample_count !== exp_count) begin
      errors++;
      $display("FAIL timeout_next_count got %0d want %0d", sample_count, exp_count);
    end
  endtask

  task automatic test_overrun();
    int w, n;
    bit ok, seen;
    wait_tick(ok);
    accept(16'hA5A5);
    wait_enable_low(w, ok);
    cnv_ready = 1'b1;
    wait_start(n, ok);
    cnv_ready = 1'b0;
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL overrun_pre got %b want 0", overrun);
    end
    seen = 1'b0;
    for (int i = 0; i < 45; i++) begin
      if (sampling_light && !seen) begin
        seen = 1'b1;
        sig16b_in = 16'hDEAD;
        step();
        #1;
        checks++;
        if (overrun !== 1'b1 || sample_latched !== 16'hA5A5) begin
          errors++;
          $display("FAIL overrun_set got ovr=%b lat=%h want 1 a5a5", overrun, sample_latched);
        end
      end else begin
        step();
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL overrun_tick got none want tick during PROCESS");
    end
    finish_process();
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    #1;
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL overrun_clear got %b want 0", overrun);
    end
  endtask

  task automatic test_stale_ready();
    int j;
    bit ok;
    wait_tick(ok);
    cnv_ready = 1'b1;
    accept(16'h7777);
    j = 1;
    ok = proc_start;
    for (int i = 0; i < 20 && !ok; i++) begin
      step();
      j++;
      ok = proc_start;
    end
    cnv_ready = 1'b0;
    checks++;
    if (!ok || j < 3) begin
      errors++;
      $display("FAIL stale_ready got start at T+%0d ok=%b want >= T+3", j, ok);
    end
    finish_process();
    checks++;
    if (sample_count !== exp_count) begin
      errors++;
      $display("FAIL stale_count got %0d want %0d", sample_count, exp_count);
    end
  endtask

  task automatic test_run_drop();
    int w, n, ticks;
    bit ok;
    wait_tick(ok);
    accept(16'h1357);
    wait_enable_low(w, ok);
    cnv_ready = 1'b1;
    wait_start(n, ok);
    cnv_ready = 1'b0;
    run = 1'b0;
    step();
    #1;
    checks++;
    if (sampling_cycle_counter !== 13'd0) begin
      errors++;
      $display("FAIL run_drop_counter got %0d want 0", sampling_cycle_counter);
    end
    ticks = 0;
    for (int i = 0; i < 45; i++) begin
      if (sampling_light || cnv_enable) ticks++;
      step();
    end
    checks++;
    if (ticks != 0) begin
      errors++;
      $display("FAIL run_drop_ticks got %0d want 0", ticks);
    end
    finish_process();
    checks++;
    if (out_enable !== 1'b1 || sample_count !== exp_count) begin
      errors++;
      $display("FAIL run_drop_done got oe=%b sc=%0d want 1 %0d", out_enable, sample_count, exp_count);
    end
  endtask

  task automatic test_reset_mid();
    int w, s0;
    bit ok;
    run = 1'b1;
    wait_tick(ok);
    sig16b_in = 16'h9999;
    step();
    wait_enable_low(w, ok);
    s0 = n_start;
    rst = 1'b1;
    run = 1'b0;
    step();
    #1;
    checks++;
    if ({sampling_cycle_counter, sampling_light, sample_latched, cnv_enable, proc_start,
         out_enable, busy, overrun, timeout_err, sample_count} !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs got lat=%h busy=%b sc=%0d want all 0",
               sample_latched, busy, sample_count);
    end
    exp_count = 16'd0;
    rst = 1'b0;
    cnv_ready = 1'b1;
    repeat (6) step();
    cnv_ready = 1'b0;
    checks++;
    if (n_start != s0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_no_start got starts=%0d busy=%b want 0 0", n_start - s0, busy);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover got %0d pending want 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_timeout();
    test_overrun();
    test_stale_ready();
    test_run_drop();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
